// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared widths and FSM state type for the sine table reader
package synth_pkg;

    localparam int PHASE_W_DEF = 24;
    localparam int TABLE_AW    = 9;
    localparam int SAMPLE_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/sample_scaler.sv
// rtl/sample_scaler.sv - offset-binary table word to signed sample, scaled by volume/256
module sample_scaler
    import synth_pkg::*;
(
    input  logic [SAMPLE_W-1:0] i_rdata,
    input  logic [7:0]          i_volume,
    output logic [SAMPLE_W-1:0] o_sample
);

    logic [SAMPLE_W-1:0] w_s;
    logic signed [23:0]  w_s_ext;
    logic signed [23:0]  w_vol_ext;
    logic signed [23:0]  w_prod;

    // 16x8 product magnitude stays below 2^23, so 24 bits never overflow
    assign w_s       = i_rdata ^ 16'h8000;
    assign w_s_ext   = {{8{w_s[SAMPLE_W-1]}}, w_s};
    assign w_vol_ext = {16'd0, i_volume};
    assign w_prod    = w_s_ext * w_vol_ext;
    assign o_sample  = SAMPLE_W'(w_prod >>> 8);

endmodule

// File: rtl/sin_table_reader.sv
// rtl/sin_table_reader.sv - phase accumulator driving a registered-read sine RAM
module sin_table_reader
    import synth_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_sample_tick,
    input  logic [PHASE_W-1:0]  i_ftw,
    input  logic                i_phase_sync,
    input  logic [7:0]          i_volume,
    output logic [TABLE_AW-1:0] o_ram_addr,
    output logic [SAMPLE_W-1:0] o_ram_wdata,
    input  logic [SAMPLE_W-1:0] i_ram_rdata,
    output logic                o_ce,
    output logic                o_re,
    output logic                o_we,
    output logic [SAMPLE_W-1:0] o_sample_out,
    output logic                o_sample_valid,
    output logic                o_busy,
    output logic                o_overrun,
    input  logic                i_overrun_clr
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PHASE_W-1:0]    r_phase;
    logic [PHASE_W-1:0]    w_phase_sum;
    logic [TABLE_AW-1:0]   r_ram_addr;
    logic [SAMPLE_W-1:0]   r_sample_out;
    logic                  r_sample_valid;
    logic                  r_overrun;
    logic                  w_tick_accept;
    logic                  w_tick_drop;
    logic                  w_capture;
    logic [SAMPLE_W-1:0]   w_scaled;

    sample_scaler u_scaler (
        .i_rdata  (i_ram_rdata),
        .i_volume (i_volume),
        .o_sample (w_scaled)
    );

    assign w_phase_sum = r_phase + i_ftw;

    // phase_sync overrides everything: it aborts a read and swallows a same-cycle tick
    always_comb begin
        w_state_nxt   = r_state;
        w_tick_accept = 1'b0;
        w_tick_drop   = 1'b0;
        w_capture     = 1'b0;
        if (i_phase_sync) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_sample_tick) begin
                        w_tick_accept = 1'b1;
                        w_state_nxt   = ST_READ;
                    end
                end
                ST_READ: begin
                    w_tick_drop = i_sample_tick;
                    w_state_nxt = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    w_tick_drop = i_sample_tick;
                    w_capture   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_phase        <= '0;
            r_ram_addr     <= '0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_sample_valid <= w_capture;
            if (i_phase_sync) begin
                r_phase    <= '0;
                r_ram_addr <= '0;
            end else if (w_tick_accept) begin
                r_phase    <= w_phase_sum;
                r_ram_addr <= w_phase_sum[PHASE_W-1 -: TABLE_AW];
            end
            if (w_capture) begin
                r_sample_out <= w_scaled;
            end
            if (w_tick_drop) begin
                r_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_ram_addr     = r_ram_addr;
    assign o_ram_wdata    = '0;
    assign o_ce           = (r_state == ST_READ);
    assign o_re           = (r_state == ST_READ);
    assign o_we           = 1'b0;
    assign o_sample_out   = r_sample_out;
    assign o_sample_valid = r_sample_valid;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_sin_table_reader.sv
// tb/tb_sin_table_reader.sv - directed vector bench with a registered-read sine RAM model
module tb_sin_table_reader;

    logic        clk;
    logic        rst;
    logic        sample_tick;
    logic [23:0] ftw;
    logic        phase_sync;
    logic [7:0]  volume;
    logic [8:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ce;
    logic        re;
    logic        we;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        overrun;
    logic        overrun_clr;

    int n_checks;
    int n_errors;

    logic [15:0] sine_rom [512];

    typedef struct {
        logic        sync_first;
        logic [23:0] ftw;
        logic [7:0]  vol;
        logic [8:0]  exp_addr;
        logic [15:0] exp_sample;
    } vec_t;

    vec_t vecs [7];

    sin_table_reader #(.PHASE_W(24)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_sample_tick  (sample_tick),
        .i_ftw          (ftw),
        .i_phase_sync   (phase_sync),
        .i_volume       (volume),
        .o_ram_addr     (ram_addr),
        .o_ram_wdata    (ram_wdata),
        .i_ram_rdata    (ram_rdata),
        .o_ce           (ce),
        .o_re           (re),
        .o_we           (we),
        .o_sample_out   (sample_out),
        .o_sample_valid (sample_valid),
        .o_busy         (busy),
        .o_overrun      (overrun),
        .i_overrun_clr  (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 512; i++) begin
            sine_rom[i] = 16'($rtoi(32767.5 + 32767.5 * $sin(2.0 * 3.141592653589793 * i / 512.0)));
        end
    end

    always @(posedge clk) begin
        if (ce && re) ram_rdata <= sine_rom[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_sync();
        phase_sync = 1'b1;
        @(negedge clk);
        phase_sync = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        if (v.sync_first) do_sync();
        ftw         = v.ftw;
        volume      = v.vol;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check($sformatf("v%0d_addr", idx), 32'(ram_addr), 32'(v.exp_addr));
        check($sformatf("v%0d_re_t1", idx), 32'(re), 32'd1);
        check($sformatf("v%0d_ce_t1", idx), 32'(ce), 32'd1);
        check($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
        @(negedge clk);
        check($sformatf("v%0d_re_t2", idx), 32'(re), 32'd0);
        check($sformatf("v%0d_valid_t2", idx), 32'(sample_valid), 32'd0);
        check($sformatf("v%0d_addr_hold", idx), 32'(ram_addr), 32'(v.exp_addr));
        @(negedge clk);
        check($sformatf("v%0d_valid_t3", idx), 32'(sample_valid), 32'd1);
        check($sformatf("v%0d_sample", idx), 32'(sample_out), 32'(v.exp_sample));
        @(negedge clk);
        check($sformatf("v%0d_valid_t4", idx), 32'(sample_valid), 32'd0);
        check($sformatf("v%0d_sample_hold", idx), 32'(sample_out), 32'(v.exp_sample));
        check($sformatf("v%0d_we_wdata", idx), {15'd0, we, ram_wdata}, 32'd0);
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (sample_valid) cnt++;
        end
    endtask

    initial begin
        int   cnt;
        vec_t v;
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        sample_tick = 1'b0;
        ftw         = '0;
        phase_sync  = 1'b0;
        volume      = '0;
        overrun_clr = 1'b0;

        vecs[0] = '{1'b0, 24'h400000, 8'd255, 9'd128, 16'(32639)};
        vecs[1] = '{1'b0, 24'h400000, 8'd255, 9'd256, 16'(-1)};
        vecs[2] = '{1'b0, 24'h400000, 8'd255, 9'd384, 16'(-32640)};
        vecs[3] = '{1'b0, 24'h400000, 8'd255, 9'd0,   16'(-1)};
        vecs[4] = '{1'b1, 24'h008000, 8'd255, 9'd1,   16'(399)};
        vecs[5] = '{1'b1, 24'hFF8000, 8'd255, 9'd511, 16'(-402)};
        vecs[6] = '{1'b0, 24'hFF8000, 8'd0,   9'd510, 16'(0)};

        repeat (3) @(negedge clk);
        check("rst_outputs", {ram_addr, ce, re, we, busy, overrun, sample_valid}, 32'd0);
        check("rst_sample", 32'(sample_out), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // dropped tick while busy sets overrun and leaves phase alone
        do_sync();
        ftw         = 24'h008000;
        volume      = 8'd255;
        sample_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sample_tick = 1'b0;
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_addr", 32'(ram_addr), 32'd1);
        count_valid(6, cnt);
        check("ovr_one_valid", 32'(cnt), 32'd1);
        v = '{1'b0, 24'h008000, 8'd0, 9'd2, 16'(0)};
        run_vec(v, 10);

        sample_tick = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("ovr_set_wins", 32'(overrun), 32'd1);
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        repeat (2) @(negedge clk);

        // abort a read with phase_sync
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("sync_in_read", 32'(re), 32'd1);
        do_sync();
        check("sync_busy", 32'(busy), 32'd0);
        check("sync_addr", 32'(ram_addr), 32'd0);
        count_valid(4, cnt);
        check("sync_no_valid", 32'(cnt), 32'd0);
        v = '{1'b0, 24'h008000, 8'd255, 9'd1, 16'(399)};
        run_vec(v, 11);

        // phase_sync with a simultaneous tick
        sample_tick = 1'b1;
        phase_sync  = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        phase_sync  = 1'b0;
        check("synctick_busy", 32'(busy), 32'd0);
        check("synctick_ovr", 32'(overrun), 32'd0);
        check("synctick_addr", 32'(ram_addr), 32'd0);

        // reset asserted during CAPTURE, with overrun pending
        ftw         = 24'hFF8000;
        sample_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sample_tick = 1'b0;
        check("rstcap_state", {30'd0, busy, re}, 32'd2);
        check("rstcap_ovr_pre", 32'(overrun), 32'd1);
        rst = 1'b1;
        #1;
        check("rstcap_outputs", {ram_addr, ce, re, we, busy, overrun, sample_valid}, 32'd0);
        check("rstcap_sample", 32'(sample_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_valid(4, cnt);
        check("rstcap_no_valid", 32'(cnt), 32'd0);
        run_vec(vecs[0], 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
